// File: rtl/sifh_hist_engine_pkg.sv
// Shared definitions for the SiFH histogram engine: FSM state encoding,
// default parameters and width helpers.
package sifh_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        SCAN  = 3'd4,
        EMIT  = 3'd5
    } state_e;

    localparam int DEF_PIX_W            = 2;
    localparam int DEF_BIN_W            = 5;
    localparam int DEF_CNT_W            = 8;
    localparam int DEF_EVT_W            = 24;
    localparam int DEF_EVENTS_PER_FRAME = 1024;

    function automatic int addr_t_width(input int pix_w, input int bin_w);
        return pix_w + bin_w;
    endfunction

    function automatic int cnt_t_width(input int cnt_w);
        return (cnt_w > 0) ? cnt_w : 1;
    endfunction

endpackage

// File: rtl/sifh_hist_engine_peak_tracker.sv
// Running max/argmax register; strict greater-than keeps the lowest bin on ties.
module sifh_peak_tracker
    import sifh_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             init_i,
    input  logic             upd_i,
    input  logic [BIN_W-1:0] bin_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [BIN_W-1:0] max_bin_o,
    output logic [CNT_W-1:0] max_cnt_o
);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next max/argmax selection
    always_comb begin
        bin_d = bin_q;
        cnt_d = cnt_q;
        if (init_i) begin
            bin_d = '0;
            cnt_d = '0;
        end else if (upd_i && (cnt_i > cnt_q)) begin
            bin_d = bin_i;
            cnt_d = cnt_i;
        end else begin
            bin_d = bin_q;
            cnt_d = cnt_q;
        end
    end

    // Max/argmax registers
    always_ff @(posedge clk) begin
        if (res) begin
            bin_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            cnt_q <= cnt_d;
        end
    end

    assign max_bin_o = bin_q;
    assign max_cnt_o = cnt_q;

endmodule

// File: rtl/sifh_hist_engine.sv
// SiFH dToF histogram engine: clears, accumulates and peak-scans per-pixel
// time-of-flight histograms held in an external dual-port RAM.
module sifh_hist_engine
    import sifh_pkg::*;
#(
    parameter int PIX_W            = DEF_PIX_W,
    parameter int BIN_W            = DEF_BIN_W,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int EVT_W            = DEF_EVT_W,
    parameter int EVENTS_PER_FRAME = DEF_EVENTS_PER_FRAME
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   start,
    input  logic                   clr_on_scan,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [PIX_W+BIN_W-1:0] ev_data,
    output logic [PIX_W+BIN_W-1:0] ram_raddr,
    output logic                   ram_re,
    input  logic [CNT_W-1:0]       ram_rdata,
    output logic [PIX_W+BIN_W-1:0] ram_waddr,
    output logic                   ram_we,
    output logic [CNT_W-1:0]       ram_wdata,
    output logic                   pk_valid,
    input  logic                   pk_ready,
    output logic [PIX_W-1:0]       pk_pixel,
    output logic [BIN_W-1:0]       pk_bin,
    output logic [CNT_W-1:0]       pk_count,
    output logic                   busy
);

    localparam int AW  = addr_t_width(PIX_W, BIN_W);
    localparam int CW  = cnt_t_width(CNT_W);
    localparam logic [EVT_W-1:0] LAST_EVT = EVT_W'(EVENTS_PER_FRAME - 1);

    state_e           state_q, state_d;
    logic             first_frame_q, first_frame_d;
    logic             clr_mode_q, clr_mode_d;
    logic [AW-1:0]    clr_addr_q, clr_addr_d;
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic [AW-1:0]    s1_addr_q, s1_addr_d;
    logic             fwd_valid_q, fwd_valid_d;
    logic [AW-1:0]    fwd_addr_q, fwd_addr_d;
    logic [CW-1:0]    fwd_data_q, fwd_data_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [BIN_W:0]   sidx_q, sidx_d;

    logic             ev_hs_s;
    logic             fwd_hit_s;
    logic [CW-1:0]    old_cnt_s;
    logic [CW-1:0]    new_cnt_s;
    logic [BIN_W:0]   prev_idx_s;
    logic             trk_init_s;
    logic             trk_upd_s;

    assign ev_hs_s    = (state_q == ACCUM) && ev_valid;
    // Stage 1 must see the write issued last cycle, which the RAM returns stale.
    assign fwd_hit_s  = fwd_valid_q && (fwd_addr_q == s1_addr_q);
    assign old_cnt_s  = fwd_hit_s ? fwd_data_q : ram_rdata;
    assign new_cnt_s  = (old_cnt_s == {CW{1'b1}}) ? old_cnt_s : (old_cnt_s + CW'(1));
    assign prev_idx_s = sidx_q - (BIN_W+1)'(1);

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (first_frame_q || !clr_mode_q) ? CLEAR : ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (clr_addr_q == {AW{1'b1}}) begin
                    state_d = ACCUM;
                end else begin
                    state_d = CLEAR;
                end
            end
            ACCUM: begin
                if (ev_hs_s && (evt_cnt_q == LAST_EVT)) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: state_d = SCAN;
            SCAN: begin
                if (sidx_q[BIN_W]) begin
                    state_d = EMIT;
                end else begin
                    state_d = SCAN;
                end
            end
            EMIT: begin
                if (pk_ready) begin
                    state_d = (pix_q == {PIX_W{1'b1}}) ? IDLE : SCAN;
                end else begin
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: RAM ports, event ready and tracker control
    always_comb begin
        ev_ready   = 1'b0;
        ram_re     = 1'b0;
        ram_raddr  = '0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;
        trk_init_s = 1'b0;
        trk_upd_s  = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
            end
            ACCUM, DRAIN: begin
                ev_ready = (state_q == ACCUM);
                if (ev_hs_s) begin
                    ram_re    = 1'b1;
                    ram_raddr = ev_data;
                end else begin
                    ram_re    = 1'b0;
                end
                if (s1_valid_q) begin
                    ram_we    = 1'b1;
                    ram_waddr = s1_addr_q;
                    ram_wdata = new_cnt_s;
                end else begin
                    ram_we    = 1'b0;
                end
            end
            SCAN: begin
                if (!sidx_q[BIN_W]) begin
                    ram_re    = 1'b1;
                    ram_raddr = {pix_q, sidx_q[BIN_W-1:0]};
                end else begin
                    ram_re    = 1'b0;
                end
                if (sidx_q == '0) begin
                    trk_init_s = 1'b1;
                end else begin
                    trk_upd_s = 1'b1;
                    ram_we    = clr_mode_q;
                    ram_waddr = {pix_q, prev_idx_s[BIN_W-1:0]};
                end
            end
            default: begin
                ev_ready = 1'b0;
            end
        endcase
    end

    // Datapath next-state: counters, pipeline stage 1 and forward register
    always_comb begin
        first_frame_d = first_frame_q;
        clr_mode_d    = clr_mode_q;
        clr_addr_d    = clr_addr_q;
        evt_cnt_d     = evt_cnt_q;
        s1_valid_d    = 1'b0;
        s1_addr_d     = s1_addr_q;
        fwd_valid_d   = fwd_valid_q;
        fwd_addr_d    = fwd_addr_q;
        fwd_data_d    = fwd_data_q;
        pix_d         = pix_q;
        sidx_d        = sidx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_mode_d = clr_on_scan;
                    evt_cnt_d  = '0;
                    clr_addr_d = '0;
                end else begin
                    clr_mode_d = clr_mode_q;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == {AW{1'b1}}) begin
                    first_frame_d = 1'b0;
                end else begin
                    first_frame_d = first_frame_q;
                end
            end
            ACCUM: begin
                if (ev_hs_s) begin
                    s1_valid_d = 1'b1;
                    s1_addr_d  = ev_data;
                    evt_cnt_d  = evt_cnt_q + EVT_W'(1);
                end else begin
                    s1_valid_d = 1'b0;
                end
                fwd_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    fwd_addr_d = s1_addr_q;
                    fwd_data_d = new_cnt_s;
                end else begin
                    fwd_addr_d = fwd_addr_q;
                end
            end
            DRAIN: begin
                fwd_valid_d = 1'b0;
                pix_d       = '0;
                sidx_d      = '0;
            end
            SCAN: sidx_d = sidx_q + (BIN_W+1)'(1);
            EMIT: begin
                if (pk_ready) begin
                    pix_d  = pix_q + PIX_W'(1);
                    sidx_d = '0;
                end else begin
                    pix_d  = pix_q;
                end
            end
            default: begin
                s1_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (res) begin
            first_frame_q <= 1'b1;
            clr_mode_q    <= 1'b0;
            clr_addr_q    <= '0;
            evt_cnt_q     <= '0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            fwd_valid_q   <= 1'b0;
            fwd_addr_q    <= '0;
            fwd_data_q    <= '0;
            pix_q         <= '0;
            sidx_q        <= '0;
        end else begin
            first_frame_q <= first_frame_d;
            clr_mode_q    <= clr_mode_d;
            clr_addr_q    <= clr_addr_d;
            evt_cnt_q     <= evt_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_addr_q     <= s1_addr_d;
            fwd_valid_q   <= fwd_valid_d;
            fwd_addr_q    <= fwd_addr_d;
            fwd_data_q    <= fwd_data_d;
            pix_q         <= pix_d;
            sidx_q        <= sidx_d;
        end
    end

    sifh_peak_tracker #(
        .BIN_W (BIN_W),
        .CNT_W (CNT_W)
    ) u_peak (
        .clk       (clk),
        .res       (res),
        .init_i    (trk_init_s),
        .upd_i     (trk_upd_s),
        .bin_i     (prev_idx_s[BIN_W-1:0]),
        .cnt_i     (ram_rdata),
        .max_bin_o (pk_bin),
        .max_cnt_o (pk_count)
    );

    assign pk_valid = (state_q == EMIT);
    assign pk_pixel = pix_q;
    assign busy     = (state_q != IDLE);

endmodule
